// File: rtl/mem_loader.sv
// mem_loader: packs a byte stream little-endian into dw-bit words and writes
// them to a single-port memory from a programmed base address for a programmed
// word count.
// Optional feature macro: MEM_LOADER_CHECKSUM_EN (running mod-256 byte sum on
// the checksum port; when undefined the port is tied to zero).
module mem_loader #(
    parameter int aw = 10,
    parameter int dw = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [aw-1:0] base_addr,
    input  logic [aw:0]   len,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    output logic          we,
    output logic [aw-1:0] waddr,
    output logic [dw-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic [7:0]    checksum
);

    localparam int LANES = dw / 8;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [LW-1:0] LANE_ONE  = 1;
    localparam logic [aw-1:0] ADDR_ONE  = 1;
    localparam logic [aw:0]   CNT_ONE   = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [aw-1:0]   addr_q, addr_d;
    logic [aw:0]     remain_q, remain_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [dw-1:0]   pack_q, pack_d;
    logic            we_q, we_d;
    logic [aw-1:0]   waddr_q, waddr_d;
    logic [dw-1:0]   wdata_q, wdata_d;
    logic            s_ready_q, busy_q, done_q;
    logic            accept;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [7:0]      sum_q, sum_d;
`endif

    assign accept = s_valid && s_ready_q;

    // Next-state logic: transfer sequencing, byte packing and word emission.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        lane_d   = lane_q;
        pack_d   = pack_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
`ifdef MEM_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    remain_d = len;
                    lane_d   = '0;
`ifdef MEM_LOADER_CHECKSUM_EN
                    sum_d    = '0;
`endif
                    // An empty transfer still spends one busy cycle so that
                    // done lands two cycles after start, like a real flush.
                    state_d  = (len == '0) ? FLUSH : LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (lane_q == LW'(i)) begin
                            pack_d[8*i +: 8] = s_data;
                        end
                    end
`ifdef MEM_LOADER_CHECKSUM_EN
                    sum_d = sum_q + s_data;
`endif
                    if (lane_q == LAST_LANE) begin
                        we_d     = 1'b1;
                        waddr_d  = addr_q;
                        wdata_d  = pack_d;
                        addr_d   = addr_q + ADDR_ONE;
                        remain_d = remain_q - CNT_ONE;
                        lane_d   = '0;
                        if (remain_q == CNT_ONE) begin
                            state_d = FLUSH;
                        end
                    end else begin
                        lane_d = lane_q + LANE_ONE;
                    end
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers; reset returns to IDLE and drops any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            s_ready_q <= (state_d == LOAD);
            busy_q    <= (state_d == LOAD) || (state_d == FLUSH);
            done_q    <= (state_d == DONE);
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    // Datapath registers; always reloaded by start before they are used.
    always_ff @(posedge clk) begin
        addr_q   <= addr_d;
        remain_q <= remain_d;
        lane_q   <= lane_d;
        pack_q   <= pack_d;
    end

    assign s_ready = s_ready_q;
    assign we      = we_q;
    assign waddr   = waddr_q;
    assign wdata   = wdata_q;
    assign busy    = busy_q;
    assign done    = done_q;
`ifdef MEM_LOADER_CHECKSUM_EN
    assign checksum = sum_q;
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Testbench for mem_loader: directed and randomized transfers checked against
// a word-list reference model built from the byte stream.
module tb_mem_loader;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NB = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = '0;
    logic          s_ready, we, busy, done;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [7:0]    checksum;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [AW-1:0] obs_addr[$];
    logic [DW-1:0] obs_data[$];
    int            obs_cyc[$];
    logic [7:0]    bq[$];

    mem_loader #(.aw(AW), .dw(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .we(we),
        .waddr(waddr), .wdata(wdata), .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-port monitor: record every write with the cycle it appears in.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            obs_addr.push_back(waddr);
            obs_data.push_back(wdata);
            obs_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_sum(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += bq[i];
`ifdef MEM_LOADER_CHECKSUM_EN
        return 8'(s % 256);
`else
        return 8'(s * 0);
`endif
    endfunction

    // Run one transfer with the bytes in bq; gap_mode 0=none 1=alternate 2=random.
    task automatic run_xfer(input logic [AW-1:0] base, input int n, input int gap_mode,
                            input bit poke_start, input string tag);
        int idx = 0;
        int cycles = 0;
        int total = n * NB;
        int ec[$];
        bit v, acc;
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
        start = 1'b1; base_addr = base; len = (AW+1)'(n);
        step();
        start = 1'b0;
        check({tag, " busy after start"}, busy, 1);
        check({tag, " s_ready after start"}, s_ready, (n != 0));
        if (n == 0) begin
            check({tag, " done early"}, done, 0);
            step();
            check({tag, " done"}, done, 1);
            check({tag, " busy at done"}, busy, 0);
            step();
            check({tag, " no writes"}, obs_addr.size(), 0);
            check({tag, " checksum"}, checksum, 0);
            return;
        end
        while (idx < total && cycles < 500) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cycles % 2) == 0;
                default: v = 1'($urandom_range(0, 1));
            endcase
            s_valid = v;
            s_data  = bq[idx];
            if (poke_start && cycles == 3) begin
                start = 1'b1; base_addr = 10'h2AA; len = 11'd5;
            end
            acc = v && (s_ready === 1'b1);
            step();
            start = 1'b0;
            cycles++;
            if (acc) begin
                if (idx % NB == NB - 1) ec.push_back(cyc);
                idx++;
            end
            if (idx < total) check({tag, " s_ready held"}, s_ready, 1);
        end
        s_valid = 1'b0;
        if (cycles >= 500) check({tag, " byte timeout"}, 0, 1);
        check({tag, " s_ready after last"}, s_ready, 0);
        check({tag, " busy in flush"}, busy, 1);
        check({tag, " done in flush"}, done, 0);
        step();
        check({tag, " done"}, done, 1);
        check({tag, " busy at done"}, busy, 0);
        check({tag, " checksum at done"}, checksum, exp_sum(total));
        step();
        check({tag, " done one cycle"}, done, 0);
        check({tag, " checksum held"}, checksum, exp_sum(total));
        check({tag, " write count"}, obs_addr.size(), n);
        for (int k = 0; k < n && k < obs_addr.size(); k++) begin
            logic [DW-1:0] w = '0;
            for (int j = 0; j < NB; j++) w = w | (DW'(bq[k*NB + j]) << (8 * j));
            check({tag, " waddr"}, obs_addr[k], (int'(base) + k) % (1 << AW));
            check({tag, " wdata"}, obs_data[k], w);
            if (k < ec.size()) check({tag, " we latency"}, obs_cyc[k], ec[k]);
        end
    endtask

    initial begin
        // Reset with s_valid high.
        rst = 1'b1; s_valid = 1'b1; s_data = 8'h5A;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst s_ready", s_ready, 0);
            check("rst we", we, 0);
            check("rst waddr", waddr, 0);
            check("rst wdata", wdata, 0);
            check("rst busy", busy, 0);
            check("rst done", done, 0);
            check("rst checksum", checksum, 0);
        end
        rst = 1'b0; s_valid = 1'b0;
        step();
        check("idle s_ready", s_ready, 0);

        // Basic transfer.
        bq.delete();
        for (int i = 1; i <= 8; i++) bq.push_back(8'(i));
        run_xfer(10'h010, 2, 0, 1'b0, "basic");
        check("basic word0", obs_data[0], 32'h04030201);
        check("basic word1", obs_data[1], 32'h08070605);
        check("basic addr1", obs_addr[1], 10'h011);
`ifdef MEM_LOADER_CHECKSUM_EN
        check("basic sum", checksum, 8'h24);
`endif

        // Same stream with alternating valid gaps.
        run_xfer(10'h010, 2, 1, 1'b0, "gaps");

        // Address wrap.
        run_xfer(10'h3FF, 2, 0, 1'b0, "wrap");
        check("wrap addr1", obs_addr[1], 10'h000);

        // Zero-length transfer.
        run_xfer(10'h123, 0, 0, 1'b0, "len0");

        // Start pulsed while busy is ignored.
        bq.delete();
        for (int i = 0; i < 3 * NB; i++) bq.push_back(8'($urandom));
        run_xfer(10'h040, 3, 0, 1'b1, "busy_start");
        step();
        check("busy_start idle", busy, 0);

        // Reset mid-word discards the partial word.
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
        start = 1'b1; base_addr = 10'h100; len = 11'd1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = 8'(8'h11 * (i + 1));
            step();
        end
        rst = 1'b1; s_data = 8'h44;
        step();
        rst = 1'b0; s_valid = 1'b0;
        check("midrst busy", busy, 0);
        check("midrst s_ready", s_ready, 0);
        check("midrst we", we, 0);
        step(); step();
        check("midrst no writes", obs_addr.size(), 0);
        bq.delete();
        bq.push_back(8'hAA); bq.push_back(8'hBB); bq.push_back(8'hCC); bq.push_back(8'hDD);
        run_xfer(10'h100, 1, 0, 1'b0, "after_rst");
        check("after_rst word", obs_data[0], 32'hDDCCBBAA);

        // Randomized transfers.
        for (int r = 0; r < 6; r++) begin
            int n = $urandom_range(1, 5);
            logic [AW-1:0] b = AW'($urandom);
            bq.delete();
            for (int i = 0; i < n * NB; i++) bq.push_back(8'($urandom));
            run_xfer(b, n, 2, 1'b0, "random");
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
